merlin_imem_bridge: RTL

MERLIN_IMEM_BRIDGE -- requirements
Module: merlin_imem_bridge

---
 rtl/merlin_imem_bridge.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/merlin_imem_bridge.sv
// merlin_imem_bridge: single-outstanding instruction fetch bridge between the
// fetch unit's valid/ready request/response channels and a req/gnt/rvalid
// memory port. Out-of-range fetches and memory timeouts become error
// responses. A read that times out after its grant leaves an "orphan" behind:
// the late read data is discarded before any new fetch is accepted.
module merlin_imem_bridge #(
  parameter int                   RV_XLEN       = 32,
  parameter logic [RV_XLEN-1:0]   C_ADDR_BASE   = 32'h0000_0000,
  parameter int                   C_ADDR_SIZE_X = 16,
  parameter int                   C_TIMEOUT_X   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  // fetch request channel
  output logic               ireqready_o,
  input  logic               ireqvalid_i,
  input  logic [1:0]         ireqhpl_i,
  input  logic [RV_XLEN-1:0] ireqaddr_i,
  // fetch response channel
  input  logic               irspready_i,
  output logic               irspvalid_o,
  output logic               irsprerr_o,
  output logic [RV_XLEN-1:0] irspdata_o,
  // memory port
  output logic               mreq_o,
  input  logic               mgnt_i,
  output logic [RV_XLEN-1:0] maddr_o,
  output logic [1:0]         mprot_o,
  input  logic               mrvalid_i,
  input  logic               mrerr_i,
  input  logic [RV_XLEN-1:0] mrdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

  localparam logic [RV_XLEN-1:0]     REGION_MASK = RV_XLEN'((64'd1 << C_ADDR_SIZE_X) - 64'd1);
  localparam logic [C_TIMEOUT_X-1:0] CNT_MAX     = '1;

  state_e                   state_q, state_d;
  logic [RV_XLEN-1:0]       addr_q, addr_d;
  logic [1:0]               hpl_q, hpl_d;
  logic                     rerr_q, rerr_d;
  logic [RV_XLEN-1:0]       data_q, data_d;
  logic [C_TIMEOUT_X-1:0]   cnt_q, cnt_d;
  logic                     orphan_q, orphan_d;

  logic [RV_XLEN-1:0]       req_addr;
  logic                     in_range;
  logic                     ready;
  logic                     accept;
  logic                     cnt_tc;

  assign req_addr = {ireqaddr_i[RV_XLEN-1:2], 2'b00};
  assign in_range = (req_addr & ~REGION_MASK) == C_ADDR_BASE;
  assign cnt_tc   = cnt_q == CNT_MAX;

  // Ready is gated by reset so it reads low while reset is held, even though
  // the state register already shows IDLE.
  assign ready  = ~reset_i & ~orphan_q &
                  ((state_q == IDLE) | ((state_q == RSP) & irspready_i));
  assign accept = ireqvalid_i & ready;

  assign ireqready_o = ready;
  assign irspvalid_o = state_q == RSP;
  assign irsprerr_o  = rerr_q;
  assign irspdata_o  = data_q;
  assign mreq_o      = state_q == REQ;
  assign maddr_o     = addr_q;
  assign mprot_o     = hpl_q;

  // Next-state and datapath: accept (IDLE or RSP handshake) has priority,
  // otherwise the per-state memory/timeout handling.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hpl_d    = hpl_q;
    rerr_d   = rerr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    orphan_d = orphan_q;

    // Counter saturates at terminal count rather than wrapping.
    if (((state_q == REQ) || (state_q == WAIT)) && !cnt_tc)
      cnt_d = cnt_q + 1'b1;

    // The first read data after an orphaning timeout belongs to the dead fetch.
    if (orphan_q && mrvalid_i)
      orphan_d = 1'b0;

    if (accept) begin
      addr_d = req_addr;
      hpl_d  = ireqhpl_i;
      cnt_d  = '0;
      if (in_range) begin
        state_d = REQ;
      end else begin
        state_d = RSP;
        rerr_d  = 1'b1;
        data_d  = '0;
      end
    end else begin
      case (state_q)
        REQ: begin
          // A grant on the terminal-count cycle still wins.
          if (mgnt_i) begin
            state_d = WAIT;
          end else if (cnt_tc) begin
            state_d = RSP;
            rerr_d  = 1'b1;
            data_d  = '0;
          end
        end
        WAIT: begin
          if (mrvalid_i) begin
            state_d = RSP;
            rerr_d  = mrerr_i;
            data_d  = mrdata_i;
          end else if (cnt_tc) begin
            state_d  = RSP;
            rerr_d   = 1'b1;
            data_d   = '0;
            orphan_d = 1'b1;
          end
        end
        RSP: begin
          if (irspready_i)
            state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; reset abandons any transaction outright.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      hpl_q    <= '0;
      rerr_q   <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      hpl_q    <= hpl_d;
      rerr_q   <= rerr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end

endmodule
